dmem_arbiter: RTL

- Shares the single-port Data_Memory between two requesters: port 0 is the pipeline MEM stage, port 1 is the test/debug loader.
- Arbitrates with round-robin priority and holds the granted request stable for a fixed access window.
- Returns read data with a one-cycle ack and rejects out-of-range word addresses.
- Sits between the MEM stage and Data_Memory; the hazard unit uses m0_req & ~m0_ack as the MEM-stage stall.

---
 rtl/dmem_arb_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the Data_Memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_ACC_CYCLES  = 2;
  localparam int unsigned DEF_DEPTH_WORDS = 256;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Byte address lies inside a memory of depth_words 32-bit words.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned depth_words);
    return {2'b00, addr} < (34'(depth_words) << 2);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; on a tie the port that did not win last time is chosen.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    gnt   = 1'b0;
    if (req0 && req1) begin
      gnt = ~last_grant;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port Data_Memory between the MEM stage (port 0)
// and the debug loader (port 1); each access holds its strobe for ACC_CYCLES cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ACC_CYCLES  = DEF_ACC_CYCLES,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int unsigned CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  arb_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_grant_q, last_grant_d;
  logic                    gnt_q, gnt_d;
  mem_req_t                cur_q, cur_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [1:0]              ack_q, ack_d;
  logic [1:0]              err_q, err_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;

  logic     arb_gnt;
  logic     arb_valid;
  mem_req_t sel_req;

  rr_arb2 u_rr_arb2 (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .valid      (arb_valid)
  );

  assign sel_req = arb_gnt ? '{we: m1_we, addr: m1_addr, wdata: m1_wdata}
                           : '{we: m0_we, addr: m0_addr, wdata: m0_wdata};

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    cur_d        = cur_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    ack_d        = 2'b00;
    err_d        = 2'b00;
    rdata_d      = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d        = arb_gnt;
          last_grant_d = arb_gnt;
          cur_d        = sel_req;
          if (!addr_in_range(sel_req.addr, DEPTH_WORDS)) begin
            state_d        = RESP;
            ack_d[arb_gnt] = 1'b1;
            err_d[arb_gnt] = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(ACC_CYCLES - 1);
            rd_d    = ~sel_req.we;
            wr_d    = sel_req.we;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          ack_d[gnt_q] = 1'b1;
          if (!cur_q.we) begin
            rdata_d[gnt_q] = mem_readdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          rd_d  = ~cur_q.we;
          wr_d  = cur_q.we;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      cur_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      cur_q        <= cur_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign m0_ack        = ack_q[0];
  assign m1_ack        = ack_q[1];
  assign m0_err        = err_q[0];
  assign m1_err        = err_q[1];
  assign m0_rdata      = rdata_q[0];
  assign m1_rdata      = rdata_q[1];
  assign mem_address   = cur_q.addr;
  assign mem_writedata = cur_q.wdata;
  assign mem_memread   = rd_q;
  assign mem_memwrite  = wr_q;

endmodule
